periph_slave_arbiter: RTL and testbench

Round-robin arbiter placed in front of one peripheral slave port of the peripheral interconnect. It shares that port between N_MASTER processing-element request paths and uses grant-based flow control. It records the index of each granted master in an in-order outstanding FIFO, and uses that record to route each slave response back to the master that issued the request.

---
 rtl/periph_slave_arbiter_if.sv | 62 ++++++
 rtl/periph_slave_arbiter.sv | 136 +++++++++++++
 tb/tb_periph_slave_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_slave_arbiter_if.sv
// Bus bundle between N request paths, the arbiter and one peripheral slave port.
// The slave modport is the arbiter side; the master modport is the environment.
interface periph_slave_arbiter_if #(
    parameter int N_MASTER   = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = N_MASTER,
    parameter int DEPTH      = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N_MASTER-1:0]                 data_req_i;
    logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
    logic [N_MASTER-1:0]                 data_wen_i;
    logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i;
    logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i;
    logic [N_MASTER-1:0][ID_WIDTH-1:0]   data_ID_i;
    logic [N_MASTER-1:0]                 data_gnt_o;

    logic                                data_req_o;
    logic [ADDR_WIDTH-1:0]               data_add_o;
    logic                                data_wen_o;
    logic [DATA_WIDTH-1:0]               data_wdata_o;
    logic [BE_WIDTH-1:0]                 data_be_o;
    logic [ID_WIDTH-1:0]                 data_ID_o;
    logic                                data_gnt_i;

    logic                                data_r_valid_i;
    logic [DATA_WIDTH-1:0]               data_r_rdata_i;
    logic                                data_r_opc_i;
    logic [N_MASTER-1:0]                 data_r_valid_o;
    logic [DATA_WIDTH-1:0]               data_r_rdata_o;
    logic                                data_r_opc_o;

    logic [CW-1:0]                       outstanding_o;
    logic                                error_o;

    modport slave (
        input  data_req_i, data_add_i, data_wen_i,
        input  data_wdata_i, data_be_i, data_ID_i,
        output data_gnt_o,
        output data_req_o, data_add_o, data_wen_o,
        output data_wdata_o, data_be_o, data_ID_o,
        input  data_gnt_i,
        input  data_r_valid_i, data_r_rdata_i, data_r_opc_i,
        output data_r_valid_o, data_r_rdata_o, data_r_opc_o,
        output outstanding_o, error_o
    );

    modport master (
        output data_req_i, data_add_i, data_wen_i,
        output data_wdata_i, data_be_i, data_ID_i,
        input  data_gnt_o,
        input  data_req_o, data_add_o, data_wen_o,
        input  data_wdata_o, data_be_o, data_ID_o,
        output data_gnt_i,
        output data_r_valid_i, data_r_rdata_i, data_r_opc_i,
        input  data_r_valid_o, data_r_rdata_o, data_r_opc_o,
        input  outstanding_o, error_o
    );
endinterface

// File: rtl/periph_slave_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port between N masters.
// Granted master indices are queued in order to route responses back.
module periph_slave_arbiter #(
    parameter int N_MASTER   = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = N_MASTER,
    parameter int DEPTH      = 2
) (
    input logic                   clk,
    input logic                   rst,
    periph_slave_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_MASTER);
    localparam int DW = $clog2(DEPTH);
    localparam int CW = DW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_M   = PW'(N_MASTER - 1);
    localparam logic [PW:0]   N_WIDE   = (PW + 1)'(N_MASTER);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] fifo_q [DEPTH];
    logic [DW-1:0] wr_ptr;
    logic [DW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          error_q;

    logic          found;
    logic [PW-1:0] winner;
    logic          full;
    logic          push;
    logic          pop;
    logic          spurious;

    logic [ADDR_WIDTH-1:0] add_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;
    logic [BE_WIDTH-1:0]   be_sel;
    logic [ID_WIDTH-1:0]   id_sel;
    logic                  wen_sel;
    logic [N_MASTER-1:0]   gnt;
    logic [N_MASTER-1:0]   rvalid;

    // Search upward from rr_ptr with wrap for the first requester.
    always_comb begin
        logic [PW:0] idx;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            idx = {1'b0, rr_ptr} + (PW + 1)'(i);
            if (idx >= N_WIDE) begin
                idx = idx - N_WIDE;
            end
            if (!found && bus.data_req_i[idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

    assign full     = (count == FULL_CNT);
    assign push     = bus.data_req_o & bus.data_gnt_i;
    assign pop      = bus.data_r_valid_i & (count != '0);
    assign spurious = bus.data_r_valid_i & (count == '0);

    // Payload mux and grant/response demux; zero when idle.
    always_comb begin
        add_sel   = '0;
        wdata_sel = '0;
        be_sel    = '0;
        id_sel    = '0;
        wen_sel   = 1'b0;
        gnt       = '0;
        rvalid    = '0;
        if (found) begin
            add_sel   = bus.data_add_i[winner];
            wdata_sel = bus.data_wdata_i[winner];
            be_sel    = bus.data_be_i[winner];
            id_sel    = bus.data_ID_i[winner];
            wen_sel   = bus.data_wen_i[winner];
        end
        if (push) begin
            gnt[winner] = 1'b1;
        end
        if (pop) begin
            rvalid[fifo_q[rd_ptr]] = 1'b1;
        end
    end

    assign bus.data_req_o     = (|bus.data_req_i) & ~full;
    assign bus.data_add_o     = add_sel;
    assign bus.data_wdata_o   = wdata_sel;
    assign bus.data_be_o      = be_sel;
    assign bus.data_ID_o      = id_sel;
    assign bus.data_wen_o     = wen_sel;
    assign bus.data_gnt_o     = gnt;
    assign bus.data_r_valid_o = rvalid;
    assign bus.data_r_rdata_o = bus.data_r_rdata_i;
    assign bus.data_r_opc_o   = bus.data_r_opc_i;
    assign bus.outstanding_o  = count;
    assign bus.error_o        = error_q;

    // Pointers, occupancy, priority rotation and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            error_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (winner == LAST_M) ? '0 : winner + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (spurious) begin
                error_q <= 1'b1;
            end
        end
    end

    // Index storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= winner;
        end
    end
endmodule

// File: tb/tb_periph_slave_arbiter.sv
// Directed bench for periph_slave_arbiter with N_MASTER=16, DEPTH=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_periph_slave_arbiter;
    localparam int NM = 16;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int IW = NM;
    localparam int DP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   seq[6] = '{0, 3, 5, 0, 3, 5};

    always #5 clk = ~clk;

    periph_slave_arbiter_if #(
        .N_MASTER(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BE_WIDTH(BW), .ID_WIDTH(IW), .DEPTH(DP)
    ) bus ();

    periph_slave_arbiter #(
        .N_MASTER(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BE_WIDTH(BW), .ID_WIDTH(IW), .DEPTH(DP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] oh(int m);
        return 32'(1) << m;
    endfunction

    function automatic logic [31:0] addr_of(int m);
        return 32'h4000_0000 + 32'(m * 16);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        bus.data_req_i     = '0;
        bus.data_gnt_i     = 1'b0;
        bus.data_r_valid_i = 1'b0;
        bus.data_r_rdata_i = '0;
        bus.data_r_opc_i   = 1'b0;
    endtask

    task automatic zero_payload();
        bus.data_add_i   = '0;
        bus.data_wen_i   = '0;
        bus.data_wdata_i = '0;
        bus.data_be_i    = '0;
        bus.data_ID_i    = '0;
    endtask

    task automatic load_payload();
        for (int m = 0; m < NM; m++) begin
            bus.data_add_i[m]   = addr_of(m);
            bus.data_wen_i[m]   = m[0];
            bus.data_wdata_i[m] = 32'hD000_0000 | 32'(m);
            bus.data_be_i[m]    = 4'(m);
            bus.data_ID_i[m]    = 16'(oh(m));
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_req"}, 32'(bus.data_req_o), 32'd0);
        chk({tag, "_gnt"}, 32'(bus.data_gnt_o), 32'd0);
        chk({tag, "_add"}, bus.data_add_o, 32'd0);
        chk({tag, "_wdata"}, bus.data_wdata_o, 32'd0);
        chk({tag, "_id"}, 32'(bus.data_ID_o), 32'd0);
        chk({tag, "_rv"}, 32'(bus.data_r_valid_o), 32'd0);
        chk({tag, "_out"}, 32'(bus.outstanding_o), 32'd0);
        chk({tag, "_err"}, 32'(bus.error_o), 32'd0);
    endtask

    initial begin
        idle_in();
        zero_payload();

        // reset and idle
        rst = 1'b1;
        tick();
        tick();
        settle();
        chk_all_zero("rst");
        rst = 1'b0;
        tick();
        settle();
        chk_all_zero("idle");

        // round-robin order with 1-cycle responses
        load_payload();
        bus.data_gnt_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.data_req_i     = 16'b10_1001;
            bus.data_r_valid_i = (k > 0);
            bus.data_r_rdata_i = 32'hA0 + 32'(k);
            settle();
            chk("rr_gnt", 32'(bus.data_gnt_o), oh(seq[k]));
            chk("rr_add", bus.data_add_o, addr_of(seq[k]));
            chk("rr_be", 32'(bus.data_be_o), 32'(seq[k]));
            chk("rr_wen", 32'(bus.data_wen_o), 32'(seq[k] % 2));
            chk("rr_rdata", bus.data_r_rdata_o, 32'hA0 + 32'(k));
            if (k > 0) begin
                chk("rr_rv", 32'(bus.data_r_valid_o), oh(seq[k-1]));
            end
            tick();
            chk("rr_out", 32'(bus.outstanding_o), 32'd1);
        end
        bus.data_req_i     = '0;
        bus.data_r_valid_i = 1'b1;
        bus.data_r_opc_i   = 1'b1;
        settle();
        chk("rr_rv_last", 32'(bus.data_r_valid_o), oh(5));
        chk("rr_opc", 32'(bus.data_r_opc_o), 32'd1);
        tick();
        chk("rr_out_end", 32'(bus.outstanding_o), 32'd0);
        idle_in();

        // slave stall: master 2 keeps priority
        bus.data_req_i = 16'(oh(2));
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("st_req", 32'(bus.data_req_o), 32'd1);
            chk("st_add", bus.data_add_o, addr_of(2));
            chk("st_gnt", 32'(bus.data_gnt_o), 32'd0);
            tick();
            chk("st_out", 32'(bus.outstanding_o), 32'd0);
        end
        bus.data_gnt_i = 1'b1;
        settle();
        chk("st_gnt_up", 32'(bus.data_gnt_o), oh(2));
        tick();
        chk("st_out1", 32'(bus.outstanding_o), 32'd1);
        bus.data_req_i     = '0;
        bus.data_r_valid_i = 1'b1;
        settle();
        chk("st_rv", 32'(bus.data_r_valid_o), oh(2));
        tick();
        idle_in();

        // FIFO full, starting from rr_ptr=0 after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("fu_rst_out", 32'(bus.outstanding_o), 32'd0);
        bus.data_req_i = 16'h0012;
        bus.data_gnt_i = 1'b1;
        settle();
        chk("fu_gnt1", 32'(bus.data_gnt_o), oh(1));
        tick();
        chk("fu_out1", 32'(bus.outstanding_o), 32'd1);
        settle();
        chk("fu_gnt4", 32'(bus.data_gnt_o), oh(4));
        tick();
        chk("fu_out2", 32'(bus.outstanding_o), 32'd2);
        settle();
        chk("fu_req_blk", 32'(bus.data_req_o), 32'd0);
        chk("fu_gnt_blk", 32'(bus.data_gnt_o), 32'd0);
        tick();
        chk("fu_out_hold", 32'(bus.outstanding_o), 32'd2);
        bus.data_r_valid_i = 1'b1;
        settle();
        chk("fu_rv1", 32'(bus.data_r_valid_o), oh(1));
        chk("fu_req_pop", 32'(bus.data_req_o), 32'd0);
        chk("fu_gnt_pop", 32'(bus.data_gnt_o), 32'd0);
        tick();
        chk("fu_out_pop", 32'(bus.outstanding_o), 32'd1);
        bus.data_r_valid_i = 1'b0;
        bus.data_gnt_i     = 1'b0;
        settle();
        chk("fu_req_again", 32'(bus.data_req_o), 32'd1);
        tick();
        bus.data_req_i     = '0;
        bus.data_r_valid_i = 1'b1;
        settle();
        chk("fu_rv4", 32'(bus.data_r_valid_o), oh(4));
        tick();
        chk("fu_out0", 32'(bus.outstanding_o), 32'd0);
        idle_in();

        // simultaneous push and pop; rr_ptr is now 5
        bus.data_req_i = 16'(oh(6));
        bus.data_gnt_i = 1'b1;
        settle();
        chk("pp_gnt6", 32'(bus.data_gnt_o), oh(6));
        tick();
        chk("pp_out1", 32'(bus.outstanding_o), 32'd1);
        bus.data_req_i     = 16'(oh(9));
        bus.data_r_valid_i = 1'b1;
        settle();
        chk("pp_gnt9", 32'(bus.data_gnt_o), oh(9));
        chk("pp_rv6", 32'(bus.data_r_valid_o), oh(6));
        tick();
        chk("pp_out_same", 32'(bus.outstanding_o), 32'd1);
        bus.data_req_i = '0;
        settle();
        chk("pp_rv9", 32'(bus.data_r_valid_o), oh(9));
        tick();
        chk("pp_out0", 32'(bus.outstanding_o), 32'd0);
        chk("pp_err0", 32'(bus.error_o), 32'd0);
        idle_in();

        // spurious response, sticky error
        bus.data_r_valid_i = 1'b1;
        settle();
        chk("sp_rv", 32'(bus.data_r_valid_o), 32'd0);
        chk("sp_err_pre", 32'(bus.error_o), 32'd0);
        tick();
        chk("sp_err", 32'(bus.error_o), 32'd1);
        chk("sp_out", 32'(bus.outstanding_o), 32'd0);
        bus.data_r_valid_i = 1'b0;
        bus.data_req_i     = 16'(oh(3));
        bus.data_gnt_i     = 1'b1;
        tick();
        bus.data_req_i     = '0;
        bus.data_r_valid_i = 1'b1;
        settle();
        chk("sp_rv3", 32'(bus.data_r_valid_o), oh(3));
        tick();
        chk("sp_err_stick", 32'(bus.error_o), 32'd1);
        idle_in();

        // reset mid-operation discards the outstanding entry
        bus.data_req_i = 16'(oh(0));
        bus.data_gnt_i = 1'b1;
        tick();
        chk("mr_out1", 32'(bus.outstanding_o), 32'd1);
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_out0", 32'(bus.outstanding_o), 32'd0);
        chk("mr_err0", 32'(bus.error_o), 32'd0);
        bus.data_r_valid_i = 1'b1;
        settle();
        chk("mr_rv", 32'(bus.data_r_valid_o), 32'd0);
        tick();
        chk("mr_err1", 32'(bus.error_o), 32'd1);
        idle_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
